// File: rtl/shift_seq.sv
// Multi-cycle shifter: loads an 8-bit operand and applies up to 7 single-bit shifts, one per clock, behind a START/BUSY/DONE handshake.
// Optional feature macro: SHIFT_SEQ_ROTATE_EN adds the ROT port (9-bit rotate through carry).
module shift_seq #(
   parameter int DELAY_RISE = 0,
   parameter int DELAY_FALL = 0
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic [1:0] OP_SEL,
   input  logic [2:0] COUNT,
   input  logic [7:0] VALUE_IN,
`ifdef SHIFT_SEQ_ROTATE_EN
   input  logic       ROT,
`endif
   output logic [7:0] VALUE_OUT,
   output logic       CARRY_OUT,
   output logic       BUSY,
   output logic       DONE
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] value_q, value_d;
   logic       carry_q, carry_d;
   logic [2:0] remaining_q, remaining_d;
   logic       left_q, left_d;
   logic       fill;

   // Delays only matter to gate-level simulation; this RTL is zero-delay.
   if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_negative_delay
   end

`ifdef SHIFT_SEQ_ROTATE_EN
   logic rot_q, rot_d;
   assign fill = rot_q ? carry_q : 1'b0;
`else
   assign fill = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      value_d     = value_q;
      carry_d     = carry_q;
      remaining_d = remaining_q;
      left_d      = left_q;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_d       = rot_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (START) begin
               carry_d     = 1'b0;
               left_d      = ~OP_SEL[0];
               remaining_d = COUNT;
`ifdef SHIFT_SEQ_ROTATE_EN
               rot_d       = ROT;
`endif
               value_d     = (OP_SEL == 2'b00) ? 8'h00 : VALUE_IN;
               state_d     = (OP_SEL[1] && COUNT != 3'd0) ? ST_SHIFT : ST_DONE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (left_q) begin
               carry_d = value_q[7];
               value_d = {value_q[6:0], fill};
            end else begin
               carry_d = value_q[0];
               value_d = {fill, value_q[7:1]};
            end
            remaining_d = remaining_q - 3'd1;
            if (remaining_q == 3'd1) begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Reset abandons any operation in flight and clears the visible result.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         value_q     <= 8'h00;
         carry_q     <= 1'b0;
         remaining_q <= 3'd0;
         left_q      <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
         rot_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         value_q     <= value_d;
         carry_q     <= carry_d;
         remaining_q <= remaining_d;
         left_q      <= left_d;
`ifdef SHIFT_SEQ_ROTATE_EN
         rot_q       <= rot_d;
`endif
      end
   end

   assign VALUE_OUT = value_q;
   assign CARRY_OUT = carry_q;
   assign BUSY      = (state_q == ST_SHIFT);
   assign DONE      = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: driver pushes expected results from an arithmetic reference model, monitor checks each DONE pulse.
// Honours SHIFT_SEQ_ROTATE_EN to exercise the ROT port.
module tb_shift_seq;

   logic       CLK = 1'b0;
   logic       RST;
   logic       START;
   logic [1:0] OP_SEL;
   logic [2:0] COUNT;
   logic [7:0] VALUE_IN;
`ifdef SHIFT_SEQ_ROTATE_EN
   logic       ROT;
`endif
   logic [7:0] VALUE_OUT;
   logic       CARRY_OUT;
   logic       BUSY;
   logic       DONE;

   shift_seq dut (
      .CLK      (CLK),
      .RST      (RST),
      .START    (START),
      .OP_SEL   (OP_SEL),
      .COUNT    (COUNT),
      .VALUE_IN (VALUE_IN),
`ifdef SHIFT_SEQ_ROTATE_EN
      .ROT      (ROT),
`endif
      .VALUE_OUT(VALUE_OUT),
      .CARRY_OUT(CARRY_OUT),
      .BUSY     (BUSY),
      .DONE     (DONE)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] val;
      logic       carry;
      int         done_cyc;
      int         busy;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   passed = 0;
   int   busy_run = 0;
   logic [7:0] last_val = 8'h00;
   logic       last_carry = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference: shifting by n is plain multiply/divide by 2^n; rotate treats {carry,value} as a 9-bit word.
   function automatic void refModel(input logic [1:0] op, input int n, input logic [7:0] v,
                                    input bit rot, output logic [7:0] rv, output logic rc);
      int x;
      rv = v;
      rc = 1'b0;
      case (op)
         2'b00: rv = 8'h00;
         2'b01: rv = v;
         2'b10: begin
            if (rot) begin
               x = int'(v);
               for (int i = 0; i < n; i++) x = ((x << 1) | (x >> 8)) & 'h1FF;
               rv = x[7:0];
               rc = x[8];
            end else begin
               x  = int'(v) * (1 << n);
               rv = x[7:0];
               rc = (n > 0) ? x[8] : 1'b0;
            end
         end
         default: begin
            if (rot) begin
               x = int'(v) * 2;
               for (int i = 0; i < n; i++) x = (x >> 1) | ((x & 1) << 8);
               rv = x[8:1];
               rc = x[0];
            end else begin
               x  = (int'(v) * 2) / (1 << n);
               rv = x[8:1];
               rc = (n > 0) ? x[0] : 1'b0;
            end
         end
      endcase
   endfunction

   // Called at a negedge with the DUT in IDLE or DONE; junk START pulses are driven while it is busy.
   task automatic applyStimulus(input logic [1:0] op, input logic [2:0] cnt, input logic [7:0] val,
                                input bit rot, input int idle_after);
      exp_t e;
      int   busy_cycles;
      busy_cycles = (op[1] && cnt != 3'd0) ? int'(cnt) : 0;
      refModel(op, int'(cnt), val, rot, e.val, e.carry);
      e.busy     = busy_cycles;
      e.done_cyc = cyc + 1 + busy_cycles;
      sbq.push_back(e);
      START    = 1'b1;
      OP_SEL   = op;
      COUNT    = cnt;
      VALUE_IN = val;
`ifdef SHIFT_SEQ_ROTATE_EN
      ROT      = rot;
`endif
      @(negedge CLK);
      for (int i = 0; i < busy_cycles; i++) begin
         START    = 1'($urandom_range(0, 1));
         OP_SEL   = 2'($urandom);
         COUNT    = 3'($urandom);
         VALUE_IN = 8'($urandom);
`ifdef SHIFT_SEQ_ROTATE_EN
         ROT      = 1'($urandom);
`endif
         @(negedge CLK);
      end
      START = 1'b0;
      repeat (idle_after) @(negedge CLK);
   endtask

   // Monitor: pops one expectation per DONE pulse and checks idle hold in between.
   always @(negedge CLK) begin
      exp_t e;
      if (RST) begin
         busy_run   = 0;
         last_val   = 8'h00;
         last_carry = 1'b0;
      end else begin
         if (BUSY) busy_run++;
         if (DONE) begin
            checkOutput("busy_with_done", {31'd0, BUSY}, 32'd0);
            if (sbq.size() == 0) begin
               checkOutput("unexpected_done", {31'd0, DONE}, 32'd0);
            end else begin
               e = sbq.pop_front();
               checkOutput("value", {24'd0, VALUE_OUT}, {24'd0, e.val});
               checkOutput("carry", {31'd0, CARRY_OUT}, {31'd0, e.carry});
               checkOutput("done_cycle", cyc, e.done_cyc);
               checkOutput("busy_cycles", busy_run, e.busy);
               last_val   = e.val;
               last_carry = e.carry;
            end
            busy_run = 0;
         end else if (!BUSY) begin
            checkOutput("hold_value", {24'd0, VALUE_OUT}, {24'd0, last_val});
            checkOutput("hold_carry", {31'd0, CARRY_OUT}, {31'd0, last_carry});
            busy_run = 0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL timeout: got running, expected finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int guard;
      RST      = 1'b1;
      START    = 1'b0;
      OP_SEL   = 2'b00;
      COUNT    = 3'd0;
      VALUE_IN = 8'h00;
`ifdef SHIFT_SEQ_ROTATE_EN
      ROT      = 1'b0;
`endif
      repeat (3) @(negedge CLK);
      checkOutput("reset_value", {24'd0, VALUE_OUT}, 32'd0);
      checkOutput("reset_carry", {31'd0, CARRY_OUT}, 32'd0);
      checkOutput("reset_busy", {31'd0, BUSY}, 32'd0);
      checkOutput("reset_done", {31'd0, DONE}, 32'd0);
      RST = 1'b0;
      @(negedge CLK);

      $display("[TB] directed cases");
      applyStimulus(2'b10, 3'd1, 8'h81, 1'b0, 1);
      applyStimulus(2'b11, 3'd3, 8'h81, 1'b0, 1);
      applyStimulus(2'b10, 3'd7, 8'hA5, 1'b0, 1);
      applyStimulus(2'b10, 3'd0, 8'h5A, 1'b0, 1);
      applyStimulus(2'b00, 3'd5, 8'hFF, 1'b0, 0);
      applyStimulus(2'b01, 3'd2, 8'h3C, 1'b0, 2);
      applyStimulus(2'b11, 3'd7, 8'h80, 1'b0, 0);
      applyStimulus(2'b11, 3'd1, 8'h01, 1'b0, 1);
`ifdef SHIFT_SEQ_ROTATE_EN
      applyStimulus(2'b10, 3'd2, 8'h81, 1'b1, 1);
      applyStimulus(2'b10, 3'd2, 8'h81, 1'b0, 1);
      applyStimulus(2'b11, 3'd3, 8'h03, 1'b1, 0);
`endif

      $display("[TB] reset mid-shift");
      START    = 1'b1;
      OP_SEL   = 2'b10;
      COUNT    = 3'd6;
      VALUE_IN = 8'hC3;
      @(negedge CLK);
      START = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      checkOutput("midreset_value", {24'd0, VALUE_OUT}, 32'd0);
      checkOutput("midreset_carry", {31'd0, CARRY_OUT}, 32'd0);
      checkOutput("midreset_busy", {31'd0, BUSY}, 32'd0);
      checkOutput("midreset_done", {31'd0, DONE}, 32'd0);
      RST = 1'b0;
      repeat (8) @(negedge CLK);

      $display("[TB] random traffic");
      for (int k = 0; k < 300; k++) begin
         logic [1:0] op;
         bit rot;
         op  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : {1'b1, 1'($urandom)};
         rot = 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
         rot = 1'($urandom);
`endif
         applyStimulus(op, 3'($urandom), 8'($urandom), rot, $urandom_range(0, 2));
      end

      guard = 0;
      while (sbq.size() != 0 && guard < 50) begin
         @(negedge CLK);
         guard++;
      end
      checkOutput("drain", sbq.size(), 32'd0);
      repeat (3) @(negedge CLK);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
